// File: rtl/axis_fifo_reader_pkg.sv
// rtl/axis_fifo_reader_pkg.sv - shared widths, buffer sizing and issue rule for axis_fifo_reader
package axis_fifo_reader_pkg;
    localparam int RFSOC_BUS_WIDTH = 256;
    localparam int RFSOC_CNT_WIDTH = 32;
    localparam int BUF_DEPTH       = 4;
    localparam int PTR_WIDTH       = 2;
    localparam int OCC_WIDTH       = 3;
    localparam int BEAT_WIDTH      = 16;
    localparam logic [OCC_WIDTH-1:0] ISSUE_LIMIT = 3'd3;

    typedef logic [PTR_WIDTH-1:0] buf_ptr_t;
    typedef logic [OCC_WIDTH-1:0] buf_occ_t;

    // One spare entry absorbs the read issued in the same cycle the limit is reached.
    function automatic logic can_issue(input buf_occ_t occ, input logic inflight);
        return (occ + {2'b00, inflight}) < ISSUE_LIMIT;
    endfunction
endpackage

// File: rtl/axis_fifo_reader_buf.sv
// rtl/axis_fifo_reader_buf.sv - 4-entry circular skid buffer between FIFO read port and stream
module axis_fifo_reader_buf
    import axis_fifo_reader_pkg::*;
#(
    parameter int bus_width = RFSOC_BUS_WIDTH
) (
    input  logic                 axis_clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [bus_width-1:0] wdata,
    input  logic                 rd,
    output logic [bus_width-1:0] rdata,
    output buf_occ_t             occ
);
    logic [bus_width-1:0] mem [BUF_DEPTH];
    buf_ptr_t             wptr;
    buf_ptr_t             rptr;

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 2'd1;
            end
            if (rd) begin
                rptr <= rptr + 2'd1;
            end
            case ({wr, rd})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign rdata = mem[rptr];
endmodule

// File: rtl/axis_fifo_reader.sv
// rtl/axis_fifo_reader.sv - FIFO read-side controller presenting an AXI-stream master with TLAST framing
module axis_fifo_reader
    import axis_fifo_reader_pkg::*;
#(
    parameter int bus_width = RFSOC_BUS_WIDTH,
    parameter int cnt_width = RFSOC_CNT_WIDTH
) (
    input  logic                  axis_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [BEAT_WIDTH-1:0] burst_len,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [bus_width-1:0]  fifo_rd_data,
    output logic [bus_width-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [cnt_width-1:0]  word_count,
    output logic [cnt_width-1:0]  underrun_count
);
    logic                  inflight;
    logic                  started;
    logic                  pop;
    buf_occ_t              occ;
    logic [BEAT_WIDTH-1:0] beat_cnt;

    assign m_axis_tvalid = (occ != '0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid & (burst_len != '0) & (beat_cnt >= burst_len - 16'd1);

    axis_fifo_reader_buf #(
        .bus_width(bus_width)
    ) u_buf (
        .axis_clk(axis_clk),
        .rst     (rst),
        .wr      (inflight),
        .wdata   (fifo_rd_data),
        .rd      (pop),
        .rdata   (m_axis_tdata),
        .occ     (occ)
    );

    always_ff @(posedge axis_clk) begin
        if (rst) begin
            fifo_rd_en     <= 1'b0;
            inflight       <= 1'b0;
            started        <= 1'b0;
            beat_cnt       <= '0;
            word_count     <= '0;
            underrun_count <= '0;
        end else begin
            // Registered terms only, so tready never reaches the FIFO pop.
            fifo_rd_en <= enable & ~fifo_empty & can_issue(occ, inflight);
            inflight   <= fifo_rd_en;
            if (pop) begin
                word_count <= word_count + 1'b1;
                started    <= 1'b1;
                beat_cnt   <= (m_axis_tlast || burst_len == '0) ? '0 : beat_cnt + 16'd1;
            end else if (burst_len == '0) begin
                beat_cnt <= '0;
            end
            if (enable & started & m_axis_tready & (occ == '0) & ~&underrun_count) begin
                underrun_count <= underrun_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_fifo_reader.sv
// tb/tb_axis_fifo_reader.sv - directed self-checking bench for axis_fifo_reader
module tb_axis_fifo_reader;
    localparam int BW = 256;
    localparam int CW = 32;

    logic          axis_clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [15:0]   burst_len = 16'd0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [BW-1:0] fifo_rd_data;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [CW-1:0] word_count;
    logic [CW-1:0] underrun_count;

    int tests = 0;
    int fails = 0;

    always #5 axis_clk = ~axis_clk;

    axis_fifo_reader #(.bus_width(BW), .cnt_width(CW)) dut (
        .axis_clk      (axis_clk),
        .rst           (rst),
        .enable        (enable),
        .burst_len     (burst_len),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .word_count    (word_count),
        .underrun_count(underrun_count)
    );

    // FIFO model: 1-cycle read latency, empty flag already accounts for the pop being requested.
    logic [BW-1:0] fmem [1024];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   underflows = 0;
    logic flush = 1'b0;
    int   fifo_cnt;
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_cnt - ((fifo_rd_en === 1'b1) ? 1 : 0)) <= 0;

    always @(posedge axis_clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en === 1'b1) begin
            if (fifo_cnt > 0) begin
                fifo_rd_data <= fmem[rd_ptr % 1024];
                rd_ptr       <= rd_ptr + 1;
            end else begin
                underflows <= underflows + 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge axis_clk) cyc <= cyc + 1;

    logic [BW-1:0] rx_data [512];
    logic          rx_last [512];
    int            rx_cyc  [512];
    int            rx_n = 0;

    logic          stall_q = 1'b0;
    logic [BW-1:0] stall_data;
    logic          stall_last;
    int            prev_sum = 0;
    logic          prev_rst = 1'b1;
    int            axi_viol = 0;
    int            occ_viol = 0;
    int            issue_viol = 0;
    int            stall_cnt = 0;
    int            rd_en_cnt = 0;

    always @(negedge axis_clk) begin
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1 && rst === 1'b0) begin
            rx_data[rx_n % 512] <= m_axis_tdata;
            rx_last[rx_n % 512] <= m_axis_tlast;
            rx_cyc[rx_n % 512]  <= cyc;
            rx_n                <= rx_n + 1;
        end
        if (stall_q && rst === 1'b0 &&
            (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_data || m_axis_tlast !== stall_last))
            axi_viol <= axi_viol + 1;
        stall_q    <= (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0) && (rst === 1'b0);
        stall_data <= m_axis_tdata;
        stall_last <= m_axis_tlast;
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b0 && rst === 1'b0)
            stall_cnt <= stall_cnt + 1;
        if (rst === 1'b0 && (dut.occ > 3'd4 || (dut.inflight === 1'b1 && dut.occ == 3'd4)))
            occ_viol <= occ_viol + 1;
        if (prev_rst === 1'b0 && fifo_rd_en === 1'b1 && prev_sum >= 3)
            issue_viol <= issue_viol + 1;
        prev_sum <= int'(dut.occ) + int'(dut.inflight);
        prev_rst <= rst;
        if (fifo_rd_en === 1'b1) rd_en_cnt <= rd_en_cnt + 1;
    end

    function automatic logic [BW-1:0] word(input int k);
        logic [31:0] v;
        v = k[31:0] ^ 32'h5A00_0000;
        return {8{v}};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    task automatic preload(input int first, input int n);
        for (int i = 0; i < n; i++) fmem[(wr_ptr + i) % 1024] = word(first + i);
        wr_ptr = wr_ptr + n;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b1; enable = 1'b0; m_axis_tready = 1'b0;
        step(1);
        rst = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; enable = 1'b0; m_axis_tready = 1'b1; burst_len = 16'd1;
        step(1);
        flush = 1'b0;
        preload(500, 3);
        enable = 1'b1;
        step(2);
        @(negedge axis_clk);
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        tests++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        tests++; if (m_axis_tdata !== '0) begin fails++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        tests++; if (word_count !== '0) begin fails++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        tests++; if (underrun_count !== '0) begin fails++; $display("FAIL reset_underrun: got %0d want 0", underrun_count); end
        tests++; if (fifo_cnt !== 3) begin fails++; $display("FAIL reset_no_pop: fifo holds %0d want 3", fifo_cnt); end
    endtask

    task automatic test_continuous();
        int t0, base, n;
        do_reset();
        preload(0, 16);
        burst_len = 16'd4; m_axis_tready = 1'b1; enable = 1'b1;
        t0 = cyc; base = rx_n;
        step(25);
        n = rx_n - base;
        tests++; if (n !== 16) begin fails++; $display("FAIL cont_count: got %0d want 16", n); end
        for (int i = 0; i < 16; i++) begin
            if (i < n) begin
                tests++;
                if (rx_data[(base + i) % 512] !== word(i) || rx_last[(base + i) % 512] !== (i % 4 == 3) ||
                    rx_cyc[(base + i) % 512] !== t0 + 3 + i) begin
                    fails++;
                    $display("FAIL cont_beat%0d: data %h last %b cycle %0d want data %h last %b cycle %0d", i,
                             rx_data[(base + i) % 512], rx_last[(base + i) % 512], rx_cyc[(base + i) % 512] - t0,
                             word(i), (i % 4 == 3), 3 + i);
                end
            end
        end
        tests++; if (word_count !== 32'd16) begin fails++; $display("FAIL cont_word_count: got %0d want 16", word_count); end
        tests++; if (underflows !== 0) begin fails++; $display("FAIL cont_underflow: got %0d want 0", underflows); end
    endtask

    task automatic test_backpressure();
        int base, n, s0;
        do_reset();
        preload(100, 20);
        burst_len = 16'd0; enable = 1'b1;
        base = rx_n; s0 = stall_cnt;
        for (int c = 0; c < 90; c++) begin
            m_axis_tready = (c % 3 == 0);
            step(1);
        end
        m_axis_tready = 1'b0;
        n = rx_n - base;
        tests++; if (n !== 20) begin fails++; $display("FAIL bp_count: got %0d want 20", n); end
        for (int i = 0; i < 20; i++) begin
            if (i < n) begin
                tests++;
                if (rx_data[(base + i) % 512] !== word(100 + i) || rx_last[(base + i) % 512] !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_beat%0d: data %h last %b want data %h last 0", i,
                             rx_data[(base + i) % 512], rx_last[(base + i) % 512], word(100 + i));
                end
            end
        end
        tests++; if (stall_cnt - s0 < 20) begin fails++; $display("FAIL bp_stalls: got %0d stalled cycles want >= 20", stall_cnt - s0); end
        tests++; if (axi_viol !== 0) begin fails++; $display("FAIL bp_axi_stable: got %0d violations want 0", axi_viol); end
        tests++; if (occ_viol !== 0) begin fails++; $display("FAIL bp_occ_bound: got %0d violations want 0", occ_viol); end
        tests++; if (issue_viol !== 0) begin fails++; $display("FAIL bp_issue_limit: got %0d violations want 0", issue_viol); end
        tests++; if (word_count !== 32'd20) begin fails++; $display("FAIL bp_word_count: got %0d want 20", word_count); end
        tests++; if (underflows !== 0) begin fails++; $display("FAIL bp_underflow: got %0d want 0", underflows); end
    endtask

    task automatic test_underrun();
        int base;
        do_reset();
        preload(200, 2);
        burst_len = 16'd0; m_axis_tready = 1'b1; enable = 1'b1;
        base = rx_n;
        step(3);
        @(negedge axis_clk);
        tests++; if (underrun_count !== '0) begin fails++; $display("FAIL underrun_before_pop: got %0d want 0", underrun_count); end
        repeat (12) @(posedge axis_clk);
        @(negedge axis_clk);
        tests++; if (underrun_count !== 32'd10) begin fails++; $display("FAIL underrun_count: got %0d want 10", underrun_count); end
        tests++; if (rx_n - base !== 2) begin fails++; $display("FAIL underrun_words: got %0d want 2", rx_n - base); end
        enable = 1'b0;
        step(5);
        tests++; if (underrun_count !== 32'd10) begin fails++; $display("FAIL underrun_hold_disabled: got %0d want 10", underrun_count); end
    endtask

    task automatic test_enable_drop();
        int base, r0;
        do_reset();
        preload(250, 5);
        m_axis_tready = 1'b1; enable = 1'b1;
        base = rx_n; r0 = rd_en_cnt;
        step(1);
        enable = 1'b0;
        @(negedge axis_clk);
        tests++; if (fifo_rd_en !== 1'b1) begin fails++; $display("FAIL drop_rd_en_c1: got %b want 1", fifo_rd_en); end
        step(10);
        tests++; if (rx_n - base !== 1) begin fails++; $display("FAIL drop_words: got %0d want 1", rx_n - base); end
        tests++; if (rx_data[base % 512] !== word(250)) begin fails++; $display("FAIL drop_data: got %h want %h", rx_data[base % 512], word(250)); end
        tests++; if (rd_en_cnt - r0 !== 1) begin fails++; $display("FAIL drop_reads: got %0d want 1", rd_en_cnt - r0); end
        tests++; if (fifo_cnt !== 4) begin fails++; $display("FAIL drop_fifo_left: got %0d want 4", fifo_cnt); end
    endtask

    task automatic test_burst_len();
        int base, n;
        logic [11:0] exp_last;
        do_reset();
        preload(300, 4);
        burst_len = 16'd1; m_axis_tready = 1'b1; enable = 1'b1;
        base = rx_n;
        step(12);
        n = rx_n - base;
        tests++; if (n !== 4) begin fails++; $display("FAIL bl1_count: got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rx_last[(base + i) % 512] !== 1'b1) begin fails++; $display("FAIL bl1_tlast%0d: got %b want 1", i, rx_last[(base + i) % 512]); end
        end
        burst_len = 16'd0;
        base = rx_n;
        preload(310, 4);
        step(12);
        n = rx_n - base;
        tests++; if (n !== 4) begin fails++; $display("FAIL bl0_count: got %0d want 4", n); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rx_last[(base + i) % 512] !== 1'b0) begin fails++; $display("FAIL bl0_tlast%0d: got %b want 0", i, rx_last[(base + i) % 512]); end
        end
        do_reset();
        preload(320, 12);
        burst_len = 16'd8; m_axis_tready = 1'b1; enable = 1'b1;
        base = rx_n;
        step(8);
        burst_len = 16'd2;
        step(15);
        exp_last = 12'b1010_1010_0000;
        n = rx_n - base;
        tests++; if (n !== 12) begin fails++; $display("FAIL bl_shrink_count: got %0d want 12", n); end
        for (int i = 0; i < 12; i++) begin
            if (i < n) begin
                tests++;
                if (rx_last[(base + i) % 512] !== exp_last[i] || rx_data[(base + i) % 512] !== word(320 + i)) begin
                    fails++;
                    $display("FAIL bl_shrink_beat%0d: last %b data %h want last %b data %h", i,
                             rx_last[(base + i) % 512], rx_data[(base + i) % 512], exp_last[i], word(320 + i));
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int base, n, w;
        do_reset();
        preload(400, 10);
        burst_len = 16'd0; m_axis_tready = 1'b1; enable = 1'b1;
        step(6);
        m_axis_tready = 1'b0;
        w = 0;
        while (dut.occ !== 3'd3 && w < 20) begin
            step(1);
            w++;
        end
        tests++; if (w >= 20) begin fails++; $display("FAIL mid_wait_occ3: got occ %0d want 3 within 20 cycles", dut.occ); end
        tests++; if (word_count !== 32'd3) begin fails++; $display("FAIL mid_pre_count: got %0d want 3", word_count); end
        rst = 1'b1; flush = 1'b1;
        step(1);
        rst = 1'b0; flush = 1'b0;
        @(negedge axis_clk);
        tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL mid_tvalid: got %b want 0", m_axis_tvalid); end
        tests++; if (word_count !== '0) begin fails++; $display("FAIL mid_word_count: got %0d want 0", word_count); end
        tests++; if (underrun_count !== '0) begin fails++; $display("FAIL mid_underrun: got %0d want 0", underrun_count); end
        tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL mid_rd_en: got %b want 0", fifo_rd_en); end
        base = rx_n;
        preload(450, 6);
        m_axis_tready = 1'b1;
        step(15);
        n = rx_n - base;
        tests++; if (n !== 6) begin fails++; $display("FAIL mid_resume_count: got %0d want 6", n); end
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                tests++;
                if (rx_data[(base + i) % 512] !== word(450 + i)) begin
                    fails++;
                    $display("FAIL mid_resume_beat%0d: got %h want %h", i, rx_data[(base + i) % 512], word(450 + i));
                end
            end
        end
        tests++; if (word_count !== 32'd6) begin fails++; $display("FAIL mid_resume_word_count: got %0d want 6", word_count); end
        tests++; if (occ_viol !== 0 || axi_viol !== 0) begin fails++; $display("FAIL mid_invariants: occ %0d axi %0d want 0 0", occ_viol, axi_viol); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_continuous();
        test_backpressure();
        test_underrun();
        test_enable_drop();
        test_burst_len();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
